alu_cmd_encoder: RTL and testbench



---
 rtl/alu_cmd_encoder.sv | 158 +++++++++++++++
 tb/tb_alu_cmd_encoder.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/alu_cmd_encoder.sv
// alu_cmd_encoder
//   Command-side counterpart of the ALU function decoder. Arbitrates up to
//   four client requests round-robin, encodes the winner onto Alu_fun,
//   strobes Alu_valid for one cycle and tracks the command until Alu_done
//   or a timeout.
//
// Parameters
//   TIMEOUT   maximum number of WAIT cycles before a command is abandoned
//             (1 .. 2**CNT_W-1)
//   CNT_W     width of the wait counter
//
// Ports
//   CLK          in   rising-edge clock
//   RST          in   asynchronous active-high reset
//   Req[3:0]     in   level requests: 0 arith, 1 logic, 2 cmp, 3 shift
//   Alu_done     in   completion pulse from the ALU
//   Alu_fun[1:0] out  encoded function (index of granted request)
//   Alu_valid    out  one-cycle command strobe
//   Grant[3:0]   out  one-hot grant, held for the whole transaction
//   Ack[3:0]     out  one-hot one-cycle completion pulse
//   Busy         out  high in ISSUE and WAIT
//   Timeout_err  out  one-cycle pulse when a command is abandoned
module alu_cmd_encoder #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] Req,
    input  logic       Alu_done,
    output logic [1:0] Alu_fun,
    output logic       Alu_valid,
    output logic [3:0] Grant,
    output logic [3:0] Ack,
    output logic       Busy,
    output logic       Timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state, state_n;
    logic [1:0]       ptr, ptr_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    logic [1:0]       fun_n;
    logic             valid_n;
    logic [3:0]       grant_n;
    logic [3:0]       ack_n;
    logic             busy_n;
    logic             terr_n;

    // Round-robin pick: first set request at or above ptr, wrapping mod 4.
    logic [1:0]       sel_idx;
    logic [3:0]       sel_oh;
    logic             sel_found;

    always_comb begin
        sel_idx   = ptr;
        sel_found = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            logic [1:0] idx;
            idx = ptr + 2'(i);
            if (!sel_found && Req[idx]) begin
                sel_idx   = idx;
                sel_found = 1'b1;
            end
        end
        sel_oh = 4'b0001 << sel_idx;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= S_IDLE;
            ptr         <= '0;
            cnt         <= '0;
            Alu_fun     <= '0;
            Alu_valid   <= 1'b0;
            Grant       <= '0;
            Ack         <= '0;
            Busy        <= 1'b0;
            Timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            cnt         <= cnt_n;
            Alu_fun     <= fun_n;
            Alu_valid   <= valid_n;
            Grant       <= grant_n;
            Ack         <= ack_n;
            Busy        <= busy_n;
            Timeout_err <= terr_n;
        end
    end

    // Next-state and next-output logic; outputs are registered so every
    // value computed here appears in the cycle of the state it leads into.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        cnt_n   = cnt;
        fun_n   = Alu_fun;
        valid_n = 1'b0;
        grant_n = Grant;
        ack_n   = '0;
        busy_n  = 1'b0;
        terr_n  = 1'b0;

        case (state)
            S_IDLE: begin
                if (Req != 4'b0000) begin
                    fun_n   = sel_idx;
                    grant_n = sel_oh;
                    valid_n = 1'b1;
                    busy_n  = 1'b1;
                    state_n = S_ISSUE;
                end
            end

            S_ISSUE: begin
                cnt_n   = '0;
                busy_n  = 1'b1;
                state_n = S_WAIT;
            end

            S_WAIT: begin
                busy_n = 1'b1;
                // Done is checked first so it wins on the timeout boundary.
                if (Alu_done) begin
                    ack_n   = Grant;
                    grant_n = '0;
                    busy_n  = 1'b0;
                    ptr_n   = Alu_fun + 2'd1;
                    state_n = S_IDLE;
                end else if (cnt == CNT_LAST) begin
                    terr_n  = 1'b1;
                    grant_n = '0;
                    busy_n  = 1'b0;
                    ptr_n   = Alu_fun + 2'd1;
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end

            default: begin
                grant_n = '0;
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_cmd_encoder.sv
module tb_alu_cmd_encoder;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] Req = 4'b0000;
    logic       Alu_done = 1'b0;
    logic [1:0] Alu_fun;
    logic       Alu_valid;
    logic [3:0] Grant;
    logic [3:0] Ack;
    logic       Busy;
    logic       Timeout_err;

    int n_checks = 0;
    int n_fails  = 0;

    alu_cmd_encoder #(.TIMEOUT(15), .CNT_W(4)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Req        (Req),
        .Alu_done   (Alu_done),
        .Alu_fun    (Alu_fun),
        .Alu_valid  (Alu_valid),
        .Grant      (Grant),
        .Ack        (Ack),
        .Busy       (Busy),
        .Timeout_err(Timeout_err)
    );

    always #5 CLK = ~CLK;

    // Packed view of all outputs: {fun[1:0], valid, grant[3:0], ack[3:0], busy, terr}
    function automatic logic [12:0] pk(input logic [1:0] f, input logic v,
                                       input logic [3:0] g, input logic [3:0] a,
                                       input logic b, input logic t);
        return {f, v, g, a, b, t};
    endfunction

    task automatic check(input string name, input logic [12:0] exp);
        logic [12:0] got;
        got = {Alu_fun, Alu_valid, Grant, Ack, Busy, Timeout_err};
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got fun=%b valid=%b grant=%b ack=%b busy=%b terr=%b, expected fun=%b valid=%b grant=%b ack=%b busy=%b terr=%b",
                     name, got[12:11], got[10], got[9:6], got[5:2], got[1], got[0],
                     exp[12:11], exp[10], exp[9:6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    // Drive inputs for the current cycle, then sample just after the edge.
    task automatic step(input logic [3:0] r, input logic d);
        Req      = r;
        Alu_done = d;
        @(posedge CLK);
        #1;
    endtask

    typedef struct {
        logic [3:0]  req;
        logic        done;
        logic [12:0] exp;
    } vec_t;

    vec_t tbl[$];

    initial begin
        // ---------------- round-robin, Req=1111, done on 1st WAIT ----------
        for (int k = 0; k < 5; k++) begin
            logic [1:0] f;
            logic [3:0] oh;
            f  = 2'(k % 4);
            oh = 4'b0001 << f;
            tbl.push_back('{4'b1111, 1'b0, pk(f, 1'b1, oh, 4'b0000, 1'b1, 1'b0)});
            tbl.push_back('{4'b1111, 1'b0, pk(f, 1'b0, oh, 4'b0000, 1'b1, 1'b0)});
            tbl.push_back('{4'b1111, 1'b1, pk(f, 1'b0, 4'b0000, oh, 1'b0, 1'b0)});
        end
        tbl.push_back('{4'b0000, 1'b0, pk(2'b00, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0)});
        // ---------------- single logic request, done on 3rd WAIT -----------
        tbl.push_back('{4'b0010, 1'b0, pk(2'b01, 1'b1, 4'b0010, 4'b0000, 1'b1, 1'b0)});
        tbl.push_back('{4'b0010, 1'b0, pk(2'b01, 1'b0, 4'b0010, 4'b0000, 1'b1, 1'b0)});
        tbl.push_back('{4'b0010, 1'b0, pk(2'b01, 1'b0, 4'b0010, 4'b0000, 1'b1, 1'b0)});
        tbl.push_back('{4'b0010, 1'b0, pk(2'b01, 1'b0, 4'b0010, 4'b0000, 1'b1, 1'b0)});
        tbl.push_back('{4'b0010, 1'b1, pk(2'b01, 1'b0, 4'b0000, 4'b0010, 1'b0, 1'b0)});
        tbl.push_back('{4'b0000, 1'b0, pk(2'b01, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0)});
        // stray done in IDLE
        tbl.push_back('{4'b0000, 1'b1, pk(2'b01, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0)});

        // ---------------- power-on reset ----------------
        @(posedge CLK);
        @(posedge CLK);
        #1;
        check("reset_state", pk(2'b00, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0));
        #2 RST = 1'b0;
        @(posedge CLK);
        #1;
        check("idle_after_reset", pk(2'b00, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0));

        // ---------------- table-driven vectors ----------------
        foreach (tbl[i]) begin
            step(tbl[i].req, tbl[i].done);
            check($sformatf("vec%0d", i), tbl[i].exp);
        end

        // ---------------- timeout, pointer at 2, Req=0100 ----------------
        step(4'b0100, 1'b0);
        check("to_issue", pk(2'b10, 1'b1, 4'b0100, 4'b0000, 1'b1, 1'b0));
        for (int k = 1; k <= 15; k++) begin
            step(4'b0100, 1'b0);
            check($sformatf("to_wait%0d", k), pk(2'b10, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b0));
        end
        step(4'b0100, 1'b0);
        check("to_err", pk(2'b10, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1));
        step(4'b0000, 1'b0);
        check("to_err_clear", pk(2'b10, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0));
        step(4'b1111, 1'b0);
        check("to_next_bit3", pk(2'b11, 1'b1, 4'b1000, 4'b0000, 1'b1, 1'b0));
        step(4'b1000, 1'b0);
        check("rw_wait", pk(2'b11, 1'b0, 4'b1000, 4'b0000, 1'b1, 1'b0));

        // ---------------- async reset mid-WAIT, then stray done ----------
        #2 RST = 1'b1;
        #1;
        check("async_reset", pk(2'b00, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0));
        #3 RST = 1'b0;
        step(4'b0000, 1'b1);
        check("rw_no_ack", pk(2'b00, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0));
        step(4'b1111, 1'b0);
        check("rw_ptr0", pk(2'b00, 1'b1, 4'b0001, 4'b0000, 1'b1, 1'b0));
        step(4'b1111, 1'b0);
        check("rw_wait1", pk(2'b00, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0));
        step(4'b0000, 1'b1);
        check("rw_ack", pk(2'b00, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b0));

        // ---------------- done exactly on WAIT cycle 15 ----------------
        step(4'b0100, 1'b0);
        check("bd_issue", pk(2'b10, 1'b1, 4'b0100, 4'b0000, 1'b1, 1'b0));
        for (int k = 1; k <= 15; k++) begin
            step(4'b0100, 1'b0);
            check($sformatf("bd_wait%0d", k), pk(2'b10, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b0));
        end
        step(4'b0100, 1'b1);
        check("bd_ack", pk(2'b10, 1'b0, 4'b0000, 4'b0100, 1'b0, 1'b0));
        step(4'b0000, 1'b0);
        check("bd_idle", pk(2'b10, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
